ipif_table_responder: RTL

- Responder (table-owning) end of the register-to-table request/ack interface.
- Holds a TBL_NUM_ROWS x (TBL_NUM_COLS*C_S_AXI_DATA_WIDTH) table in inferred dual-port RAM.
- Services row read and write requests from the register-side requester with single-cycle ack pulses.
- Also gives the packet datapath a full-throughput lookup port, which has priority over register reads.

---
 rtl/ipif_table_responder_pkg.sv | 27 ++
 rtl/ipif_table_responder_table_dpram.sv | 32 +++
 rtl/ipif_table_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ipif_table_responder_pkg.sv
// Shared definitions for the register-to-table responder: width helpers and FSM encoding.
// Pure declarations; no logic, latency or backpressure of its own.
package ipif_table_responder_pkg;

    // Address width for a table of n rows; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int row_width(input int cell_w, input int cols);
        return cell_w * cols;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ACK    = 3'd1,
        ST_RD_ISSUED = 3'd2,
        ST_RD_ACK    = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

endpackage

// File: rtl/ipif_table_responder_table_dpram.sv
// Simple dual-port RAM: write port A, registered read port B, read-first, contents never reset.
// Read data appears one cycle after re_i; no backpressure.
module table_dpram #(
    parameter int W     = 128,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Non-blocking read alongside the write gives old data on a same-row collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ipif_table_responder.sv
// Table owner for register row read/write requests (wr ack +1, rd ack +2 plus lookup stalls)
// and a fixed 2-cycle full-rate datapath lookup port that always wins the shared read port.
module ipif_table_responder
    import ipif_table_responder_pkg::*;
#(
    parameter int  C_S_AXI_DATA_WIDTH = 32,
    parameter int  TBL_NUM_COLS       = 4,
    parameter int  TBL_NUM_ROWS       = 4,
    localparam int W                  = row_width(C_S_AXI_DATA_WIDTH, TBL_NUM_COLS),
    localparam int AW                 = clog2_min1(TBL_NUM_ROWS)
) (
    input  logic          Bus2IP_Clk,
    input  logic          Bus2IP_Reset,
    input  logic          tbl_rd_req,
    output logic          tbl_rd_ack,
    input  logic [AW-1:0] tbl_rd_addr,
    output logic [W-1:0]  tbl_rd_data,
    input  logic          tbl_wr_req,
    output logic          tbl_wr_ack,
    input  logic [AW-1:0] tbl_wr_addr,
    input  logic [W-1:0]  tbl_wr_data,
    input  logic          lkup_req,
    input  logic [AW-1:0] lkup_addr,
    output logic          lkup_valid,
    output logic [W-1:0]  lkup_data
);

    localparam logic [AW:0] ROWS_L = (AW + 1)'(TBL_NUM_ROWS);

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < ROWS_L);
    endfunction

    state_t         state_q;
    logic           rd_ack_q;
    logic           wr_ack_q;
    logic           rd_oor_q;
    logic [W-1:0]   rd_data_q;
    logic           lk_s1_q;
    logic           lk_oor_s1_q;
    logic           lkup_valid_q;
    logic [W-1:0]   lkup_data_q;

    logic           idle;
    logic           ram_we;
    logic           ram_re;
    logic [AW-1:0]  ram_raddr;
    logic [W-1:0]   ram_rdata;

    assign idle      = (state_q == ST_IDLE);
    assign ram_we    = idle & tbl_wr_req & in_range(tbl_wr_addr);
    assign ram_re    = lkup_req | (idle & tbl_rd_req & ~tbl_wr_req);
    assign ram_raddr = lkup_req ? lkup_addr : tbl_rd_addr;

    table_dpram #(
        .W     (W),
        .DEPTH (TBL_NUM_ROWS),
        .AW    (AW)
    ) u_ram (
        .clk_i   (Bus2IP_Clk),
        .we_i    (ram_we),
        .waddr_i (tbl_wr_addr),
        .wdata_i (tbl_wr_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q   <= ST_IDLE;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_oor_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= 1'b0;
            wr_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tbl_wr_req) begin
                        wr_ack_q <= 1'b1;
                        state_q  <= ST_WR_ACK;
                    end else if (tbl_rd_req && !lkup_req) begin
                        rd_oor_q <= ~in_range(tbl_rd_addr);
                        state_q  <= ST_RD_ISSUED;
                    end
                end
                ST_WR_ACK: state_q <= ST_HOLDOFF;
                ST_RD_ISSUED: begin
                    rd_data_q <= rd_oor_q ? '0 : ram_rdata;
                    rd_ack_q  <= 1'b1;
                    state_q   <= ST_RD_ACK;
                end
                ST_RD_ACK: state_q <= ST_HOLDOFF;
                // Wait for the requester to drop req so a late release cannot trigger a second ack.
                ST_HOLDOFF: begin
                    if (!tbl_rd_req && !tbl_wr_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            lk_s1_q      <= 1'b0;
            lk_oor_s1_q  <= 1'b0;
            lkup_valid_q <= 1'b0;
            lkup_data_q  <= '0;
        end else begin
            lk_s1_q      <= lkup_req;
            lk_oor_s1_q  <= ~in_range(lkup_addr);
            lkup_valid_q <= lk_s1_q;
            if (lk_s1_q) begin
                lkup_data_q <= lk_oor_s1_q ? '0 : ram_rdata;
            end
        end
    end

    assign tbl_rd_ack  = rd_ack_q;
    assign tbl_wr_ack  = wr_ack_q;
    assign tbl_rd_data = rd_data_q;
    assign lkup_valid  = lkup_valid_q;
    assign lkup_data   = lkup_data_q;

endmodule
